// File: rtl/moving_sum_ctrl.sv
// moving_sum_ctrl: running sum of the last WINDOW_LEN signed samples, using an external read-first BRAM as the delay line
module moving_sum_ctrl #(
  parameter int DIN_WIDTH  = 16,
  parameter int WINDOW_LEN = 256,
  parameter int DOUT_WIDTH = DIN_WIDTH + $clog2(WINDOW_LEN)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [DIN_WIDTH-1:0]   din,
  input  logic                          din_valid,
  output logic                          ram_wen,
  output logic                          ram_ren,
  output logic [$clog2(WINDOW_LEN)-1:0] ram_wadd,
  output logic [$clog2(WINDOW_LEN)-1:0] ram_radd,
  output logic [DIN_WIDTH-1:0]          ram_win,
  input  logic [DIN_WIDTH-1:0]          ram_wout,
  output logic signed [DOUT_WIDTH-1:0]  dout,
  output logic                          dout_valid,
  output logic                          window_full
);
  localparam int AW = $clog2(WINDOW_LEN);
  logic [AW-1:0] wptr;
  logic [AW:0] cnt;
  logic signed [DIN_WIDTH-1:0] din_d, old;
  logic v1, full1, accept;
  assign accept      = din_valid & rst;
  assign ram_wen     = accept;
  assign ram_ren     = accept;
  assign ram_wadd    = wptr;
  assign ram_radd    = wptr;
  assign ram_win     = din;
  assign window_full = cnt[AW];
  // the mask is taken from the fill state when the sample was accepted, so pre-reset RAM contents never leak in
  assign old = full1 ? ram_wout : '0;
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr       <= '0;
      cnt        <= '0;
      din_d      <= '0;
      v1         <= 1'b0;
      full1      <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      v1         <= din_valid;
      dout_valid <= v1;
      if (din_valid) begin
        wptr  <= wptr + AW'(1);
        din_d <= din;
        full1 <= cnt[AW];
        if (!cnt[AW]) cnt <= cnt + (AW+1)'(1);
      end
      if (v1) dout <= dout + DOUT_WIDTH'(din_d) - DOUT_WIDTH'(old);
    end
  end
endmodule

// File: tb/tb_moving_sum_ctrl.sv
// tb_moving_sum_ctrl: directed and random checks of moving_sum_ctrl at WINDOW_LEN 4 and 256 against a sliding-window model
module tb_moving_sum_ctrl;
  localparam int DW = 16;
  logic clk = 1'b0, rst = 1'b0, din_valid = 1'b0;
  logic signed [DW-1:0] din = '0;
  logic wen_a, ren_a, dv_a, wf_a, wen_b, ren_b, dv_b, wf_b;
  logic [1:0] wadd_a, radd_a;
  logic [7:0] wadd_b, radd_b;
  logic [DW-1:0] win_a, rd_a, win_b, rd_b;
  logic signed [17:0] dout_a;
  logic signed [23:0] dout_b;
  logic [DW-1:0] mem_a [4];
  logic [DW-1:0] mem_b [256];
  int tests = 0, fails = 0;
  longint got[$];

  always #5 clk = ~clk;

  moving_sum_ctrl #(.DIN_WIDTH(DW), .WINDOW_LEN(4)) dut_a (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .ram_wen(wen_a), .ram_ren(ren_a), .ram_wadd(wadd_a), .ram_radd(radd_a),
    .ram_win(win_a), .ram_wout(rd_a), .dout(dout_a), .dout_valid(dv_a), .window_full(wf_a));

  moving_sum_ctrl #(.DIN_WIDTH(DW), .WINDOW_LEN(256)) dut_b (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .ram_wen(wen_b), .ram_ren(ren_b), .ram_wadd(wadd_b), .ram_radd(radd_b),
    .ram_win(win_b), .ram_wout(rd_b), .dout(dout_b), .dout_valid(dv_b), .window_full(wf_b));

  // read-first simple dual-port RAMs
  always @(posedge clk) begin
    if (ren_a) rd_a <= mem_a[radd_a];
    if (wen_a) mem_a[wadd_a] <= win_a;
    if (ren_b) rd_b <= mem_b[radd_b];
    if (wen_b) mem_b[wadd_b] <= win_b;
  end

  // reference: sum of the most recent accepted samples since reset, emitted one edge after acceptance
  typedef struct {int due; longint s4; longint s256;} ev_t;
  ev_t evq[$];
  int q4[$], q256[$];
  int cyc = 0, n = 0;
  longint e4 = 0, e256 = 0, ms4, ms256;
  bit ev_v = 0;
  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      evq.delete(); q4.delete(); q256.delete();
      n = 0; e4 = 0; e256 = 0; ev_v = 0;
    end else begin
      ev_v = evq.size() > 0 && evq[0].due == cyc;
      if (ev_v) begin
        e4 = evq[0].s4; e256 = evq[0].s256;
        void'(evq.pop_front());
      end
      if (din_valid) begin
        q4.push_back(int'(din)); q256.push_back(int'(din));
        if (q4.size() > 4) void'(q4.pop_front());
        if (q256.size() > 256) void'(q256.pop_front());
        ms4 = 0; ms256 = 0;
        foreach (q4[i]) ms4 += q4[i];
        foreach (q256[i]) ms256 += q256[i];
        evq.push_back('{cyc + 1, ms4, ms256});
        n++;
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  always begin
    @(posedge clk); #1;
    chk("dout_valid_a", dv_a, ev_v);
    chk("dout_valid_b", dv_b, ev_v);
    chk("dout_a", dout_a, e4);
    chk("dout_b", dout_b, e256);
    chk("window_full_a", wf_a, longint'(n >= 4));
    chk("window_full_b", wf_b, longint'(n >= 256));
    chk("ram_wadd_a", wadd_a, n % 4);
    chk("ram_radd_b", radd_b, n % 256);
    chk("ram_wen_a", wen_a, din_valid && rst);
    chk("ram_ren_b", ren_b, din_valid && rst);
    chk("ram_win_a", win_a, longint'(din) & 16'hffff);
    if (dv_a) got.push_back(dout_a);
  end

  task automatic drive(input bit r, input bit v, input int x);
    @(negedge clk);
    rst = r; din_valid = v; din = DW'(x);
  endtask

  task automatic flush();
    repeat (3) drive(1, 0, 0);
  endtask

  task automatic check_got(input string name, input longint exp[$]);
    chk({name, "_count"}, got.size(), exp.size());
    foreach (exp[i]) chk($sformatf("%s_%0d", name, i), i < got.size() ? got[i] : 64'hdead, exp[i]);
  endtask

  initial begin
    repeat (3) drive(0, 1, 123);
    chk("reset_dout", dout_a, 0);
    chk("reset_valid", dv_a, 0);
    chk("reset_full", wf_a, 0);
    got.delete();
    repeat (6) drive(1, 1, 100);
    flush();
    check_got("t1_fill", '{100, 200, 300, 400, 400, 400});
    chk("t1_full", wf_a, 1);
    repeat (4) drive(1, 1, 0);
    flush();
    got.delete();
    drive(1, 1, 1000);
    repeat (5) drive(1, 1, 0);
    flush();
    check_got("t2_impulse", '{1000, 1000, 1000, 1000, 0, 0});
    got.delete();
    repeat (8) drive(1, 1, -32768);
    repeat (4) drive(1, 1, 32767);
    flush();
    chk("t3_count", got.size(), 12);
    chk("t3_negfs", got.size() > 7 ? got[7] : 0, -131072);
    chk("t3_posfs", got.size() > 11 ? got[11] : 0, 131068);
    drive(0, 0, 0);
    got.delete();
    drive(1, 1, 5); drive(1, 0, 0); drive(1, 0, 0);
    drive(1, 1, 7); drive(1, 0, 0); drive(1, 1, 9);
    flush();
    check_got("t4_gapped", '{5, 12, 21});
    drive(0, 0, 0);
    repeat (6) drive(1, 1, 50);
    drive(0, 1, 77);
    got.delete();
    drive(1, 1, 10); drive(1, 1, 10);
    flush();
    check_got("t5_midreset", '{10, 20});
    chk("t5_full", wf_a, 0);
    drive(0, 0, 0);
    for (int i = 0; i < 1400; i++) begin
      if (i == 900) drive(0, 1, 0);
      else drive(1, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0 ? -32768 :
                 int'($urandom_range(0, 65535)) - 32768);
    end
    flush();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
